// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port round-robin arbiter in front of psram_controller.
// Waits for PSRAM init, grants one burst at a time, issues a one-cycle
// psram_exe, then routes write handshakes and read data to the owning port.
// Optional build macro: PSRAM_ARB_TIMEOUT_EN adds a BUSY watchdog that
// aborts a burst after TIMEOUT_CYC cycles and flags it on pN_err.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_WAIT_INIT | PSRAM not initialised yet, everything idle
// S_ARB       | pick a requester, latch its command, pulse its grant
// S_ISSUE     | one-cycle psram_exe strobe
// S_BUSY      | transfer in flight, route data to owner until psram_done
// S_GAP       | one idle turnaround cycle before the next arbitration
module psram_arbiter #(
  parameter logic       BIT_CTRL    = 1'b1,
  parameter logic       WRAP_EN     = 1'b1,
  parameter logic [1:0] BYTE_WRITE  = 2'b00,
  parameter logic [1:0] COMMAND     = 2'b00,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        p0_req,
  input  logic        p0_rw,
  input  logic [31:0] p0_addr,
  input  logic [11:0] p0_len,
  input  logic [15:0] p0_wdata,
  output logic        p0_grant,
  output logic        p0_wready,
  output logic [15:0] p0_rdata,
  output logic        p0_rvalid,
  output logic        p0_done,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_rw,
  input  logic [31:0] p1_addr,
  input  logic [11:0] p1_len,
  input  logic [15:0] p1_wdata,
  output logic        p1_grant,
  output logic        p1_wready,
  output logic [15:0] p1_rdata,
  output logic        p1_rvalid,
  output logic        p1_done,
  output logic        p1_err,
  input  logic        init_cable_complete,
  input  logic        psram_done,
  input  logic        psram_rd_valid,
  input  logic        psram_wr_valid,
  input  logic [15:0] psram_rd_data,
  output logic        psram_exe,
  output logic        rw_ctrl,
  output logic        bit_ctrl,
  output logic        wrap_in,
  output logic [1:0]  byte_write,
  output logic [1:0]  command_in,
  output logic [31:0] addr_in,
  output logic [11:0] burst_len,
  output logic [15:0] data_in
);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_ARB,
    S_ISSUE,
    S_BUSY,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [11:0] len_q, len_d;

  logic        win;
  logic        in_busy;
  logic        timeout_hit;
  logic        busy_done;
  logic        busy_err;

  assign in_busy = (state_q == S_BUSY);

  // State and latched command registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_WAIT_INIT;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  // Next-state, arbitration and strobe generation.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    len_d     = len_q;
    win       = 1'b0;
    p0_grant  = 1'b0;
    p1_grant  = 1'b0;
    psram_exe = 1'b0;
    busy_done = 1'b0;
    busy_err  = 1'b0;
    case (state_q)
      S_WAIT_INIT: begin
        if (init_cable_complete) state_d = S_ARB;
      end
      S_ARB: begin
        if (p0_req || p1_req) begin
          // Under contention the port that did not win last time goes next.
          win      = (p0_req && p1_req) ? ~last_q : p1_req;
          owner_d  = win;
          last_d   = win;
          rw_d     = win ? p1_rw   : p0_rw;
          addr_d   = win ? p1_addr : p0_addr;
          len_d    = win ? p1_len  : p0_len;
          p0_grant = ~win;
          p1_grant = win;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        psram_exe = 1'b1;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        // A real psram_done in the timeout cycle is a clean finish.
        if (psram_done || timeout_hit) begin
          busy_done = 1'b1;
          busy_err  = ~psram_done;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_ARB;
      end
      default: begin
        state_d = S_WAIT_INIT;
      end
    endcase
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog count: cleared on the way into BUSY, advanced every BUSY cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_ISSUE) tmo_cnt_d = '0;
    else if (in_busy)       tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = in_busy && (tmo_cnt_q == 32'(TIMEOUT_CYC));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_hit        = 1'b0;
`endif

  assign p0_wready = in_busy & ~owner_q & psram_wr_valid;
  assign p1_wready = in_busy &  owner_q & psram_wr_valid;
  assign p0_rvalid = in_busy & ~owner_q & psram_rd_valid;
  assign p1_rvalid = in_busy &  owner_q & psram_rd_valid;
  assign p0_rdata  = (in_busy && !owner_q) ? psram_rd_data : 16'h0000;
  assign p1_rdata  = (in_busy &&  owner_q) ? psram_rd_data : 16'h0000;
  assign p0_done   = busy_done & ~owner_q;
  assign p1_done   = busy_done &  owner_q;
  assign p0_err    = busy_err  & ~owner_q;
  assign p1_err    = busy_err  &  owner_q;
  assign data_in   = in_busy ? (owner_q ? p1_wdata : p0_wdata) : 16'h0000;

  assign rw_ctrl    = rw_q;
  assign addr_in    = addr_q;
  assign burst_len  = len_q;
  assign bit_ctrl   = BIT_CTRL;
  assign wrap_in    = WRAP_EN;
  assign byte_write = BYTE_WRITE;
  assign command_in = COMMAND;

endmodule
